majority_frame_collector: RTL and testbench

//  Upstream feeder for the 4-way bitwise majority voter. Accepts a serial stream of

---
 rtl/majority_frame_collector.sv | 86 ++++++++
 tb/tb_majority_frame_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/majority_frame_collector.sv
// majority_frame_collector: groups four consecutive WIDTH-bit copies into one frame for the 4-way majority voter.
// Optional COLLECT_SOF_EN adds an in_sof input that resynchronises framing on start-of-frame markers.
module majority_frame_collector #(
    parameter int WIDTH   = 15,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef COLLECT_SOF_EN
    input  logic             in_sof,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [2:0]       fill,
    output logic             drop
);
    typedef enum logic {COLLECT, PRESENT} state_t;
    state_t     state;
    logic [7:0] idle_cnt;
    logic       accept, idle, expire, resync, orphan, store;
    logic [1:0] wr_slot;

    assign in_ready = rst_n & (state == COLLECT);
    assign accept   = in_valid & in_ready;
    assign idle     = (state == COLLECT) && (fill != 3'd0) && !accept;
    // Fires on the idle cycle that would bring the counter up to TIMEOUT.
    assign expire   = (TIMEOUT != 0) && idle && (({1'b0, idle_cnt} + 9'd1) == 9'(TIMEOUT));

`ifdef COLLECT_SOF_EN
    assign resync = accept & in_sof & (fill != 3'd0);
    assign orphan = accept & ~in_sof & (fill == 3'd0);
`else
    assign resync = 1'b0;
    assign orphan = 1'b0;
`endif

    assign store   = accept & ~orphan;
    assign wr_slot = resync ? 2'd0 : fill[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            fill      <= 3'd0;
            idle_cnt  <= 8'd0;
            out_valid <= 1'b0;
            drop      <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out4      <= '0;
        end else begin
            drop <= expire | resync | orphan;
            if (state == PRESENT) begin
                idle_cnt <= 8'd0;
                if (out_ready) begin
                    state     <= COLLECT;
                    fill      <= 3'd0;
                    out_valid <= 1'b0;
                end
            end else if (store) begin
                if (wr_slot == 2'd0) out1 <= in_data;
                if (wr_slot == 2'd1) out2 <= in_data;
                if (wr_slot == 2'd2) out3 <= in_data;
                if (wr_slot == 2'd3) out4 <= in_data;
                fill     <= resync ? 3'd1 : fill + 3'd1;
                idle_cnt <= 8'd0;
                if (!resync && fill == 3'd3) begin
                    state     <= PRESENT;
                    out_valid <= 1'b1;
                end
            end else if (expire) begin
                fill     <= 3'd0;
                idle_cnt <= 8'd0;
            end else begin
                idle_cnt <= (idle && TIMEOUT != 0) ? idle_cnt + 8'd1 : 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_majority_frame_collector.sv
// tb_majority_frame_collector: directed vector table plus multi-cycle corner sequences.
module tb_majority_frame_collector;
    localparam int W = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_sof = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out1, out2, out3, out4;
    logic [2:0]   fill;
    logic         drop;

    int n_checks = 0;
    int n_fail = 0;

    majority_frame_collector #(.WIDTH(W), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef COLLECT_SOF_EN
        .in_sof(in_sof),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .fill(fill), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic         sof;
        logic [W-1:0] data;
        logic         ordy;
        logic         e_ov;
        logic [2:0]   e_fill;
        logic         e_ir;
        logic         e_drop;
        logic [W-1:0] e_o1, e_o2, e_o3, e_o4;
    } vec_t;

    vec_t vec[16];

    function automatic vec_t mk(logic v, logic s, logic [W-1:0] d, logic r, logic ov, logic [2:0] f,
                                logic ir, logic dr, logic [W-1:0] o1, logic [W-1:0] o2,
                                logic [W-1:0] o3, logic [W-1:0] o4);
        vec_t t;
        t.valid = v; t.sof = s; t.data = d; t.ordy = r; t.e_ov = ov; t.e_fill = f;
        t.e_ir = ir; t.e_drop = dr; t.e_o1 = o1; t.e_o2 = o2; t.e_o3 = o3; t.e_o4 = o4;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic s);
        in_valid = 1'b1; in_data = d; in_sof = s; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic [2:0] f, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            check({tag, "_drop"}, 32'(drop), 32'd0);
            check({tag, "_fill"}, 32'(fill), 32'(f));
        end
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_ov", 32'(out_valid), 32'd0);
        check("release_fill", 32'(fill), 32'd0);
    endtask

    initial begin
        vec[0] = mk(1, 1, 15'h0001, 0, 0, 1, 1, 0, 15'h0001, 15'h0000, 15'h0000, 15'h0000);
        vec[1] = mk(1, 0, 15'h0003, 0, 0, 2, 1, 0, 15'h0001, 15'h0003, 15'h0000, 15'h0000);
        vec[2] = mk(1, 0, 15'h7FFF, 0, 0, 3, 1, 0, 15'h0001, 15'h0003, 15'h7FFF, 15'h0000);
        vec[3] = mk(1, 0, 15'h0000, 0, 1, 4, 0, 0, 15'h0001, 15'h0003, 15'h7FFF, 15'h0000);
        for (int i = 4; i < 14; i++)
            vec[i] = mk(1, 0, 15'h5555, 0, 1, 4, 0, 0, 15'h0001, 15'h0003, 15'h7FFF, 15'h0000);
        vec[14] = mk(0, 0, 15'h0000, 1, 0, 0, 1, 0, 15'h0001, 15'h0003, 15'h7FFF, 15'h0000);
        vec[15] = mk(0, 0, 15'h0000, 0, 0, 0, 1, 0, 15'h0001, 15'h0003, 15'h7FFF, 15'h0000);

        #3;
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_ir", 32'(in_ready), 32'd0);
        check("rst_out1", 32'(out1), 32'd0);
        check("rst_out4", 32'(out4), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ir", 32'(in_ready), 32'd1);

        // Frame build, hold under backpressure, handoff
        for (int i = 0; i < 16; i++) begin
            in_valid = vec[i].valid; in_sof = vec[i].sof; in_data = vec[i].data; out_ready = vec[i].ordy;
            tick();
            check($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vec[i].e_ov));
            check($sformatf("v%0d_fill", i), 32'(fill), 32'(vec[i].e_fill));
            check($sformatf("v%0d_ir", i), 32'(in_ready), 32'(vec[i].e_ir));
            check($sformatf("v%0d_drop", i), 32'(drop), 32'(vec[i].e_drop));
            check($sformatf("v%0d_out1", i), 32'(out1), 32'(vec[i].e_o1));
            check($sformatf("v%0d_out2", i), 32'(out2), 32'(vec[i].e_o2));
            check($sformatf("v%0d_out3", i), 32'(out3), 32'(vec[i].e_o3));
            check($sformatf("v%0d_out4", i), 32'(out4), 32'(vec[i].e_o4));
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Timeout: 2 copies, then drop exactly on the 16th idle cycle
        push(15'h0011, 1'b1);
        push(15'h0022, 1'b0);
        idle_cycles(15, 3'd2, "to");
        tick();
        check("to_drop_pulse", 32'(drop), 32'd1);
        check("to_fill_cleared", 32'(fill), 32'd0);
        tick();
        check("to_drop_one_cycle", 32'(drop), 32'd0);
        push(15'h0A01, 1'b1);
        push(15'h0A02, 1'b0);
        push(15'h0A03, 1'b0);
        push(15'h0A04, 1'b0);
        check("to_clean_ov", 32'(out_valid), 32'd1);
        check("to_clean_o1", 32'(out1), 32'h0A01);
        check("to_clean_o2", 32'(out2), 32'h0A02);
        check("to_clean_o3", 32'(out3), 32'h0A03);
        check("to_clean_o4", 32'(out4), 32'h0A04);
        release_frame();

        // Accept on the exact timeout cycle wins, counter restarts
        push(15'h0101, 1'b1);
        push(15'h0102, 1'b0);
        idle_cycles(15, 3'd2, "race");
        push(15'h0103, 1'b0);
        check("race_fill", 32'(fill), 32'd3);
        check("race_no_drop", 32'(drop), 32'd0);
        check("race_out3", 32'(out3), 32'h0103);
        idle_cycles(15, 3'd3, "race2");
        tick();
        check("race2_drop", 32'(drop), 32'd1);
        check("race2_fill", 32'(fill), 32'd0);
        tick();

        // Async reset during PRESENT
        push(15'h0201, 1'b1);
        push(15'h0202, 1'b0);
        push(15'h0203, 1'b0);
        push(15'h0204, 1'b0);
        check("pres_ov", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ov", 32'(out_valid), 32'd0);
        check("arst_fill", 32'(fill), 32'd0);
        check("arst_ir", 32'(in_ready), 32'd0);
        check("arst_drop", 32'(drop), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_after_drop", 32'(drop), 32'd0);
        check("arst_after_ir", 32'(in_ready), 32'd1);

`ifdef COLLECT_SOF_EN
        push(15'h0301, 1'b1);
        push(15'h0302, 1'b0);
        push(15'h1234, 1'b1);
        check("sof_resync_drop", 32'(drop), 32'd1);
        check("sof_resync_fill", 32'(fill), 32'd1);
        push(15'h0303, 1'b0);
        check("sof_drop_clear", 32'(drop), 32'd0);
        push(15'h0304, 1'b0);
        push(15'h0305, 1'b0);
        check("sof_frame_ov", 32'(out_valid), 32'd1);
        check("sof_frame_o1", 32'(out1), 32'h1234);
        check("sof_frame_o4", 32'(out4), 32'h0305);
        release_frame();
        push(15'h0777, 1'b0);
        check("sof_orphan_drop", 32'(drop), 32'd1);
        check("sof_orphan_fill", 32'(fill), 32'd0);
        check("sof_orphan_o1", 32'(out1), 32'h1234);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
